// File: rtl/cmac_csb_reg_initiator_if.sv
// CSB request/response channel between the fabric and the CMAC register initiator.
interface cmac_csb_reg_initiator_if;
  logic        req_pvld;
  logic        req_prdy;
  logic [62:0] req_pd;
  logic        resp_valid;
  logic [33:0] resp_pd;

  // Fabric side drives requests and consumes responses.
  modport master (
    output req_pvld, req_pd,
    input  req_prdy, resp_valid, resp_pd
  );

  // Initiator side accepts requests and produces responses.
  modport slave (
    input  req_pvld, req_pd,
    output req_prdy, resp_valid, resp_pd
  );
endinterface

// File: rtl/cmac_csb_reg_initiator.sv
// CSB-to-register-file initiator: window check, one-cycle register access,
// CSB response generation and a saturating error counter.
module cmac_csb_reg_initiator #(
  parameter logic [11:0] BASE_HI = 12'h007
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  cmac_csb_reg_initiator_if.slave        csb,
  output logic [11:0]                    reg_offset,
  output logic [31:0]                    reg_wr_data,
  output logic                           reg_wr_en,
  input  logic [31:0]                    reg_rd_data,
  output logic [7:0]                     err_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [11:0] offset_q;
  logic [31:0] wdat_q;
  logic        write_q;
  logic        nposted_q;
  logic        err_q;
  logic [33:0] resp_pd_q;
  logic [7:0]  err_cnt_q;

  // Request field decode
  logic [21:0] req_addr;
  logic [31:0] req_wdat;
  logic        req_write;
  logic        req_nposted;
  logic [3:0]  req_wrbe;
  logic        req_hit;
  logic        req_bad_be;
  logic        req_err;
  logic        accept;

  assign req_addr    = csb.req_pd[21:0];
  assign req_wdat    = csb.req_pd[53:22];
  assign req_write   = csb.req_pd[54];
  assign req_nposted = csb.req_pd[55];
  assign req_wrbe    = csb.req_pd[60:57];

  // srcpriv and level carry no meaning for this responder.
  logic unused_fields;
  assign unused_fields = ^{csb.req_pd[62:61], csb.req_pd[56]};

  assign req_hit    = (req_addr[21:10] == BASE_HI);
  assign req_bad_be = req_write & (req_wrbe != 4'hF);
  assign req_err    = ~req_hit | req_bad_be;
  assign accept     = (state_q == IDLE) & csb.req_pvld;

  // State register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state: a single ACCESS cycle, then RESP unless the write is posted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csb.req_pvld) state_d = ACCESS;
      ACCESS:  state_d = (!write_q || nposted_q) ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the decoded request on acceptance; offset/data then hold until the next one
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      offset_q  <= 12'h000;
      wdat_q    <= 32'h0;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      offset_q  <= {req_addr[9:0], 2'b00};
      wdat_q    <= req_wdat;
      write_q   <= req_write;
      nposted_q <= req_nposted;
      err_q     <= req_err;
    end
  end

  // Build the response at the end of ACCESS; read data only on a clean read
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      resp_pd_q <= 34'h0;
    end else if (state_q == ACCESS && state_d == RESP) begin
      resp_pd_q <= {write_q, err_q, (!write_q && !err_q) ? reg_rd_data : 32'h0};
    end
  end

  // Count every erroneous access once, in its ACCESS cycle, saturating at 0xFF
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_cnt_q <= 8'h00;
    end else if (state_q == ACCESS && err_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign csb.req_prdy   = (state_q == IDLE);
  assign csb.resp_valid = (state_q == RESP);
  assign csb.resp_pd    = resp_pd_q;
  assign reg_offset     = offset_q;
  assign reg_wr_data    = wdat_q;
  assign reg_wr_en      = (state_q == ACCESS) & write_q & ~err_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_cmac_csb_reg_initiator.sv
// Scoreboard bench for cmac_csb_reg_initiator: expected responses and write
// strobes are queued at request acceptance and matched when the DUT emits them.
module tb_cmac_csb_reg_initiator;

  typedef struct {
    logic [33:0] pd;
    int          cyc;
  } exp_rsp_t;

  typedef struct {
    logic [11:0] off;
    logic [31:0] d;
    int          cyc;
  } exp_wr_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic [7:0]  err_cnt;

  cmac_csb_reg_initiator_if bus();

  cmac_csb_reg_initiator #(.BASE_HI(12'h007)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .csb             (bus),
    .reg_offset      (reg_offset),
    .reg_wr_data     (reg_wr_data),
    .reg_wr_en       (reg_wr_en),
    .reg_rd_data     (reg_rd_data),
    .err_cnt         (err_cnt)
  );

  int n_vec;
  int n_miss;
  int cyc;
  int last_acc;
  int rsp_count;
  int model_cnt;
  logic prev_rv;
  logic prev_we;

  exp_rsp_t rq[$];
  exp_wr_t  wq[$];

  logic [31:0] resp_mem [1024];
  logic [31:0] shadow   [1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: combinational read of a small register file, distinct from plain storage
  assign reg_rd_data = resp_mem[reg_offset[11:2]] ^ 32'h0001_0000;

  always @(posedge clk) begin
    if (reg_wr_en) resp_mem[reg_offset[11:2]] <= reg_wr_data;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard whenever the DUT emits a response or strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid) begin
        exp_rsp_t e;
        rsp_count++;
        check_val("resp_b2b", {63'h0, prev_rv}, 64'h0);
        if (rq.size() == 0) begin
          check_val("resp_unexpected", {62'h0, 2'b01}, {62'h0, 2'b00 | {1'b0, bus.resp_valid & 1'b0}});
        end else begin
          e = rq.pop_front();
          check_val("resp_pd", {30'h0, bus.resp_pd}, {30'h0, e.pd});
          check_val("resp_cyc", cyc, e.cyc);
          $display("resp  pd=%09h cyc=%0d", bus.resp_pd, cyc);
        end
      end
      if (reg_wr_en) begin
        exp_wr_t w;
        check_val("wr_en_b2b", {63'h0, prev_we}, 64'h0);
        if (wq.size() == 0) begin
          check_val("wr_unexpected", {63'h0, reg_wr_en}, 64'h0);
        end else begin
          w = wq.pop_front();
          check_val("wr_offset", {52'h0, reg_offset}, {52'h0, w.off});
          check_val("wr_data", {32'h0, reg_wr_data}, {32'h0, w.d});
          check_val("wr_cyc", cyc, w.cyc);
          $display("write off=%03h data=%08h cyc=%0d", reg_offset, reg_wr_data, cyc);
        end
      end
      prev_rv = bus.resp_valid;
      prev_we = reg_wr_en;
    end else begin
      prev_rv = 1'b0;
      prev_we = 1'b0;
    end
  end

  // Offer one request (called at a negedge), wait for acceptance, queue expectations
  task automatic send(input logic [21:0] a, input logic [31:0] d, input logic wr,
                      input logic np, input logic [3:0] be);
    int          waited;
    logic [1:0]  lvl;
    logic        spriv;
    logic        hit;
    logic        err;
    logic [31:0] rd;
    exp_rsp_t    r;
    exp_wr_t     w;
    lvl   = 2'($urandom_range(0, 3));
    spriv = 1'($urandom_range(0, 1));
    bus.req_pd   = {lvl, be, spriv, np, wr, d, a};
    bus.req_pvld = 1'b1;
    waited = 0;
    while (!bus.req_prdy && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_prdy) begin
      check_val("prdy_timeout", {63'h0, bus.req_prdy}, 64'h1);
      bus.req_pvld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    hit = (a[21:10] == 12'h007);
    err = !hit || (wr && be != 4'hF);
    if (wr && !err) begin
      w.off = {a[9:0], 2'b00};
      w.d   = d;
      w.cyc = last_acc;
      wq.push_back(w);
      shadow[a[9:0]] = d;
    end
    if (!wr || np) begin
      rd    = (!wr && !err) ? (shadow[a[9:0]] ^ 32'h0001_0000) : 32'h0;
      r.pd  = {wr, err, rd};
      r.cyc = last_acc + 1;
      rq.push_back(r);
    end
    if (err && model_cnt < 255) model_cnt++;
    $display("req   addr=%06h wr=%0b np=%0b be=%0h err=%0b acc=%0d", a, wr, np, be, err, last_acc);
    @(negedge clk);
    check_val("prdy_access", {63'h0, bus.req_prdy}, 64'h0);
    if (!wr || np) begin
      @(negedge clk);
      check_val("prdy_resp", {63'h0, bus.req_prdy}, 64'h0);
    end
  endtask

  // Drop valid, let the pipeline drain, then compare the error counter
  task automatic gap(input int n);
    bus.req_pvld = 1'b0;
    repeat (n) @(negedge clk);
    check_val("err_cnt", {56'h0, err_cnt}, 64'(model_cnt));
  endtask

  initial begin
    int acc[5];
    int rsp_base;
    n_vec = 0; n_miss = 0; cyc = 0; rsp_count = 0; model_cnt = 0;
    prev_rv = 1'b0; prev_we = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      resp_mem[i] = 32'h0;
      shadow[i]   = 32'h0;
    end
    bus.req_pvld = 1'b0;
    bus.req_pd   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check_val("rst_prdy", {63'h0, bus.req_prdy}, 64'h1);
    check_val("rst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
    check_val("rst_resp_pd", {30'h0, bus.resp_pd}, 64'h0);
    check_val("rst_offset", {52'h0, reg_offset}, 64'h0);
    check_val("rst_wr_data", {32'h0, reg_wr_data}, 64'h0);
    check_val("rst_wr_en", {63'h0, reg_wr_en}, 64'h0);
    check_val("rst_err_cnt", {56'h0, err_cnt}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-posted write then read-back
    send(22'h1C01, 32'h1, 1'b1, 1'b1, 4'hF);           gap(3);
    send(22'h1C01, 32'h0, 1'b0, 1'b0, 4'h0);           gap(3);
    // Out-of-window read
    send(22'h1801, 32'h0, 1'b0, 1'b0, 4'h0);           gap(3);
    // Partial writes, non-posted then posted
    send(22'h1C02, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'h3);   gap(3);
    send(22'h1C02, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'h3);   gap(3);

    // Mixed in-window traffic
    for (int i = 0; i < 8; i++) begin
      logic [9:0] lo;
      lo = 10'($urandom_range(0, 7));
      send({12'h007, lo}, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'hF);
      gap(2);
    end

    // Back-to-back: 3 reads then 2 posted writes with valid held high
    rsp_base = rsp_count;
    send(22'h1C01, 32'h0, 1'b0, 1'b0, 4'h0);           acc[0] = last_acc;
    send(22'h1C02, 32'h0, 1'b0, 1'b0, 4'h0);           acc[1] = last_acc;
    send(22'h1C03, 32'h0, 1'b0, 1'b0, 4'h0);           acc[2] = last_acc;
    send(22'h1C04, 32'h1234_5678, 1'b1, 1'b0, 4'hF);   acc[3] = last_acc;
    send(22'h1C05, 32'h9ABC_DEF0, 1'b1, 1'b0, 4'hF);   acc[4] = last_acc;
    gap(4);
    check_val("b2b_gap0", acc[1] - acc[0], 3);
    check_val("b2b_gap1", acc[2] - acc[1], 3);
    check_val("b2b_gap2", acc[3] - acc[2], 3);
    check_val("b2b_gap3", acc[4] - acc[3], 2);
    check_val("b2b_resp_count", rsp_count - rsp_base, 3);
    send(22'h1C04, 32'h0, 1'b0, 1'b0, 4'h0);           gap(3);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) send(22'h0C00, 32'h0, 1'b1, 1'b0, 4'h1);
    gap(3);
    check_val("err_cnt_sat", {56'h0, err_cnt}, 64'hFF);

    // Reset asserted in the ACCESS cycle of a read
    bus.req_pd   = {2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 22'h1C01};
    bus.req_pvld = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_pvld = 1'b0;
    model_cnt = 0;
    #1;
    check_val("mid_rst_prdy", {63'h0, bus.req_prdy}, 64'h1);
    check_val("mid_rst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
    check_val("mid_rst_offset", {52'h0, reg_offset}, 64'h0);
    check_val("mid_rst_err_cnt", {56'h0, err_cnt}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_base = rsp_count;
    repeat (3) @(negedge clk);
    check_val("post_rst_prdy", {63'h0, bus.req_prdy}, 64'h1);
    check_val("post_rst_no_resp", rsp_count - rsp_base, 0);
    send(22'h1C01, 32'h0, 1'b0, 1'b0, 4'h0);           gap(3);

    check_val("rsp_queue_drained", rq.size(), 0);
    check_val("wr_queue_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global bound so a stuck DUT cannot hang the run
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
